// File: rtl/eth_tx_pkg.sv
// Shared types, constants and the byte-wise CRC-32 step for the Ethernet
// transmit path.
package eth_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DST,
    ST_SRC,
    ST_LEN,
    ST_PAY,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam logic [31:0] CRC_POLY_REFL   = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE     = 32'hDEBB20E3;
  localparam int          MIN_PAYLOAD_DEF = 46;
  localparam int          IFG_CYCLES_DEF  = 12;

  // Field lengths in bytes, used as last-count values by the FSM.
  localparam logic [15:0] PRE_LAST = 16'd6;
  localparam logic [15:0] MAC_LAST = 16'd5;
  localparam logic [15:0] LEN_LAST = 16'd1;
  localparam logic [15:0] FCS_LAST = 16'd3;

  // One byte of a reflected CRC-32, data consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  // Byte idx of a MAC address, idx 0 being the most significant byte.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac,
                                          input logic [2:0]  idx);
    return mac[8*(5-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wise CRC-32 accumulator: synchronous init has priority over update.
module eth_crc32
  import eth_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  // CRC register: reload on init, fold in one byte on en.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    crc <= CRC_INIT;
    else if (init) crc <= CRC_INIT;
    else if (en)   crc <= crc32_byte(crc, data);
  end

endmodule

// File: rtl/eth_frame_encapsulator.sv
// GMII frame builder: pulls a length-prefixed packet from the payload FIFO
// and emits preamble, SFD, addresses, length, payload, pad, FCS and IFG.
// The FSM state names the byte being prepared; every output is registered,
// so the GMII stream trails the state by one cycle.
module eth_frame_encapsulator
  import eth_tx_pkg::*;
#(
  parameter logic [47:0] DEST_MAC    = 48'h023528fbdd66,
  parameter logic [47:0] SRC_MAC     = 48'h072227acdb65,
  parameter int          WIDTH       = 8,  // only 8 is supported
  parameter int          MIN_PAYLOAD = MIN_PAYLOAD_DEF,
  parameter int          IFG_CYCLES  = IFG_CYCLES_DEF
) (
  input  logic             eth_tx_clk,
  input  logic             arst_n,
  input  logic             eth_tx_en,
  input  logic [1:0]       bf_out_buffer_ready,
  input  logic [WIDTH-1:0] ff_out_data_in,
  output logic             bf_in_r_en,
  output logic             bf_in_pct_txed,
  output logic [7:0]       gmii_txd,
  output logic             gmii_tx_en
);

  localparam logic [15:0] MIN_PAY  = 16'(MIN_PAYLOAD);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

  tx_state_t   state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] len_q;
  logic [15:0] pad_last;
  logic [7:0]  byte_nxt;
  logic        en_nxt, rd_nxt, pct_nxt;
  logic        crc_init, crc_en;
  logic [31:0] crc, fcs;

  assign pad_last = MIN_PAY - len_q - 16'd1;
  assign fcs      = ~crc;

  eth_crc32 u_crc (
    .clk   (eth_tx_clk),
    .rst_n (arst_n),
    .init  (crc_init),
    .en    (crc_en),
    .data  (byte_nxt),
    .crc   (crc)
  );

  // State and byte-counter register.
  always_ff @(posedge eth_tx_clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, next byte and FIFO read request. Length reads go out in the
  // first two PRE slots; payload reads run two slots ahead of the PAY byte
  // to cover the registered read strobe plus the FIFO read latency.
  // NOTE: every signal gets a default before the case, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 16'd1;
    byte_nxt  = 8'h00;
    en_nxt    = 1'b0;
    rd_nxt    = 1'b0;
    pct_nxt   = 1'b0;
    crc_init  = 1'b0;
    crc_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (eth_tx_en && bf_out_buffer_ready != 2'd0) state_nxt = ST_PRE;
      end
      ST_PRE: begin
        byte_nxt = PREAMBLE_BYTE;
        en_nxt   = 1'b1;
        rd_nxt   = (cnt < 16'd2);
        if (cnt == PRE_LAST) begin
          state_nxt = ST_SFD;
          cnt_nxt   = '0;
        end
      end
      ST_SFD: begin
        byte_nxt  = SFD_BYTE;
        en_nxt    = 1'b1;
        crc_init  = 1'b1;
        state_nxt = ST_DST;
        cnt_nxt   = '0;
      end
      ST_DST: begin
        byte_nxt = mac_byte(DEST_MAC, cnt[2:0]);
        en_nxt   = 1'b1;
        crc_en   = 1'b1;
        if (cnt == MAC_LAST) begin
          state_nxt = ST_SRC;
          cnt_nxt   = '0;
        end
      end
      ST_SRC: begin
        byte_nxt = mac_byte(SRC_MAC, cnt[2:0]);
        en_nxt   = 1'b1;
        crc_en   = 1'b1;
        if (cnt == MAC_LAST) begin
          state_nxt = ST_LEN;
          cnt_nxt   = '0;
        end
      end
      ST_LEN: begin
        byte_nxt = cnt[0] ? len_q[7:0] : len_q[15:8];
        en_nxt   = 1'b1;
        crc_en   = 1'b1;
        rd_nxt   = (cnt < len_q);
        if (cnt == LEN_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (len_q == 16'd0) ? ST_PAD : ST_PAY;
        end
      end
      ST_PAY: begin
        byte_nxt = ff_out_data_in[7:0];
        en_nxt   = 1'b1;
        crc_en   = 1'b1;
        rd_nxt   = (({1'b0, cnt} + 17'd2) < {1'b0, len_q});
        if (cnt == len_q - 16'd1) begin
          cnt_nxt   = '0;
          state_nxt = (len_q < MIN_PAY) ? ST_PAD : ST_FCS;
        end
      end
      ST_PAD: begin
        en_nxt = 1'b1;
        crc_en = 1'b1;
        if (cnt == pad_last) begin
          state_nxt = ST_FCS;
          cnt_nxt   = '0;
        end
      end
      ST_FCS: begin
        byte_nxt = fcs[{cnt[1:0], 3'b000} +: 8];
        en_nxt   = 1'b1;
        if (cnt == FCS_LAST) begin
          state_nxt = ST_IFG;
          cnt_nxt   = '0;
        end
      end
      ST_IFG: begin
        pct_nxt = (cnt == 16'd0);
        if (cnt == IFG_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Capture the two length bytes as they return from the FIFO.
  always_ff @(posedge eth_tx_clk or negedge arst_n) begin
    if (!arst_n)                              len_q       <= '0;
    else if (state == ST_PRE && cnt == 16'd2) len_q[15:8] <= ff_out_data_in[7:0];
    else if (state == ST_PRE && cnt == 16'd3) len_q[7:0]  <= ff_out_data_in[7:0];
  end

  // Registered GMII, FIFO-read and packet-done outputs.
  always_ff @(posedge eth_tx_clk or negedge arst_n) begin
    if (!arst_n) begin
      gmii_txd       <= 8'h00;
      gmii_tx_en     <= 1'b0;
      bf_in_r_en     <= 1'b0;
      bf_in_pct_txed <= 1'b0;
    end else begin
      gmii_txd       <= byte_nxt;
      gmii_tx_en     <= en_nxt;
      bf_in_r_en     <= rd_nxt;
      bf_in_pct_txed <= pct_nxt;
    end
  end

endmodule

// File: tb/tb_eth_frame_encapsulator.sv
// Scoreboard bench for eth_frame_encapsulator: each queued packet pushes its
// full expected GMII frame; frames captured from the DUT are popped and
// compared inside each scenario task.
module tb_eth_frame_encapsulator;

  localparam logic [47:0] DEST    = 48'h023528fbdd66;
  localparam logic [47:0] SRC     = 48'h072227acdb65;
  localparam int          MIN_PAY = 46;
  localparam int          IFG     = 12;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       eth_tx_en;
  logic [1:0] ready;
  logic [7:0] fifo_dout = 8'h00;
  logic       r_en, pct, tx_en_o;
  logic [7:0] txd;

  always #5 clk = ~clk;

  eth_frame_encapsulator dut (
    .eth_tx_clk          (clk),
    .arst_n              (arst_n),
    .eth_tx_en           (eth_tx_en),
    .bf_out_buffer_ready (ready),
    .ff_out_data_in      (fifo_dout),
    .bf_in_r_en          (r_en),
    .bf_in_pct_txed      (pct),
    .gmii_txd            (txd),
    .gmii_tx_en          (tx_en_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_bytes[$];
  int         exp_lens[$];
  logic [7:0] rx_bytes[$];
  int         rx_lens[$];
  logic [7:0] cur[$];
  int         gaps[$];
  logic [7:0] got_q[$];
  logic [7:0] want_q[$];

  int   pkts_queued = 0;
  int   pkts_done   = 0;
  int   rd_count    = 0;
  int   pct_count   = 0;
  int   pct_bad     = 0;
  int   underflow   = 0;
  int   tx_cycles   = 0;
  int   idle_run    = 0;
  bit   seen_frame  = 1'b0;
  logic prev_en     = 1'b0;
  logic rd_pending  = 1'b0;

  assign ready = (pkts_queued - pkts_done > 3) ? 2'd3 : 2'(pkts_queued - pkts_done);

  // FIFO model: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_pending) begin
      if (fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
      else                   underflow <= underflow + 1;
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    rd_pending <= r_en;
    if (r_en) rd_count <= rd_count + 1;
    if (pct) begin
      pct_count <= pct_count + 1;
      pkts_done <= pkts_done + 1;
      if (!(prev_en && !tx_en_o)) pct_bad <= pct_bad + 1;
    end
    if (tx_en_o) begin
      cur.push_back(txd);
      tx_cycles <= tx_cycles + 1;
      if (!prev_en && seen_frame) gaps.push_back(idle_run);
      idle_run <= 0;
    end else begin
      idle_run <= idle_run + 1;
      if (prev_en) begin
        foreach (cur[i]) rx_bytes.push_back(cur[i]);
        rx_lens.push_back(cur.size());
        cur.delete();
        seen_frame <= 1'b1;
      end
    end
    prev_en <= tx_en_o;
  end

  function automatic logic [31:0] sw_crc(input logic [31:0] c, input logic [7:0] d);
    c = c ^ {24'h0, d};
    for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Load a packet into the FIFO model; optionally push its expected frame.
  task automatic queue_packet(input int n, input logic [7:0] base, input bit with_exp);
    logic [7:0]  fr[$];
    logic [15:0] n16;
    logic [31:0] c;
    n16 = n[15:0];
    fifo_q.push_back(n16[15:8]);
    fifo_q.push_back(n16[7:0]);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + 8'(i));
    if (with_exp) begin
      for (int i = 0; i < 7; i++) fr.push_back(8'h55);
      fr.push_back(8'hD5);
      for (int i = 0; i < 6; i++) fr.push_back(DEST[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) fr.push_back(SRC[47-8*i -: 8]);
      fr.push_back(n16[15:8]);
      fr.push_back(n16[7:0]);
      for (int i = 0; i < n; i++) fr.push_back(base + 8'(i));
      for (int i = n; i < MIN_PAY; i++) fr.push_back(8'h00);
      c = 32'hFFFFFFFF;
      for (int i = 8; i < fr.size(); i++) c = sw_crc(c, fr[i]);
      c = ~c;
      for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
      exp_lens.push_back(fr.size());
      foreach (fr[i]) exp_bytes.push_back(fr[i]);
    end
    pkts_queued++;
  endtask

  task automatic wait_frames(input int k, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rx_lens.size() >= k) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Move the next expected and captured frames into want_q / got_q.
  task automatic pop_frame(output int got_n, output int exp_n);
    got_q.delete();
    want_q.delete();
    exp_n = (exp_lens.size() > 0) ? exp_lens.pop_front() : 0;
    got_n = (rx_lens.size() > 0) ? rx_lens.pop_front() : 0;
    for (int i = 0; i < exp_n; i++) want_q.push_back(exp_bytes.pop_front());
    for (int i = 0; i < got_n; i++) got_q.push_back(rx_bytes.pop_front());
  endtask

  task automatic test_reset();
    arst_n    = 1'b0;
    eth_tx_en = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx_en_o, r_en, pct, txd} !== 11'h000) begin
      $display("FAIL reset_outputs: got en=%b r_en=%b pct=%b txd=%h, expected all 0", tx_en_o, r_en, pct, txd);
      n_bad++;
    end
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({tx_en_o, r_en, pct, txd} !== 11'h000) begin
      $display("FAIL post_reset_idle: got en=%b r_en=%b pct=%b txd=%h, expected all 0", tx_en_o, r_en, pct, txd);
      n_bad++;
    end
  endtask

  task automatic test_no_packet();
    int b_tx, b_rd;
    b_tx = tx_cycles;
    b_rd = rd_count;
    eth_tx_en = 1'b1;
    repeat (100) @(negedge clk);
    n_cmp++;
    if (tx_cycles - b_tx !== 0) begin
      $display("FAIL no_packet_tx: got %0d tx_en cycles, expected 0", tx_cycles - b_tx);
      n_bad++;
    end
    n_cmp++;
    if (rd_count - b_rd !== 0) begin
      $display("FAIL no_packet_reads: got %0d reads, expected 0", rd_count - b_rd);
      n_bad++;
    end
  endtask

  task automatic test_single_frame(input int n, input logic [7:0] base, input bit chk_res);
    int b_rd, b_pct, b_bad, b_uf, b_tx, gn, en, bad, want_len;
    bit ok;
    logic [31:0] c;
    b_rd = rd_count; b_pct = pct_count; b_bad = pct_bad; b_uf = underflow; b_tx = tx_cycles;
    want_len = 8 + 14 + ((n < MIN_PAY) ? MIN_PAY : n) + 4;
    eth_tx_en = 1'b1;
    queue_packet(n, base, 1'b1);
    wait_frames(1, 400, ok);
    n_cmp++;
    if (!ok) begin
      $display("FAIL frame_timeout N=%0d: no frame within 400 cycles", n);
      n_bad++;
      return;
    end
    pop_frame(gn, en);
    n_cmp++;
    if (gn !== en) begin
      $display("FAIL frame_len N=%0d: got %0d bytes, expected %0d", n, gn, en);
      n_bad++;
    end
    n_cmp++;
    bad = 0;
    for (int i = 0; i < gn && i < en; i++)
      if (got_q[i] !== want_q[i]) begin
        if (bad == 0) $display("FAIL frame_bytes N=%0d: byte %0d got %h expected %h", n, i, got_q[i], want_q[i]);
        bad++;
      end
    if (bad != 0) n_bad++;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (tx_cycles - b_tx !== want_len) begin
      $display("FAIL tx_en_cycles N=%0d: got %0d, expected %0d", n, tx_cycles - b_tx, want_len);
      n_bad++;
    end
    n_cmp++;
    if (rd_count - b_rd !== n + 2 || underflow !== b_uf || fifo_q.size() !== 0) begin
      $display("FAIL fifo_reads N=%0d: got %0d reads (underflow %0d, left %0d), expected %0d", n,
               rd_count - b_rd, underflow - b_uf, fifo_q.size(), n + 2);
      n_bad++;
    end
    n_cmp++;
    if (pct_count - b_pct !== 1 || pct_bad !== b_bad) begin
      $display("FAIL pct_txed N=%0d: got %0d pulses (%0d misplaced), expected 1 on first idle cycle", n,
               pct_count - b_pct, pct_bad - b_bad);
      n_bad++;
    end
    if (chk_res) begin
      c = 32'hFFFFFFFF;
      for (int i = 8; i < gn; i++) c = sw_crc(c, got_q[i]);
      n_cmp++;
      if (c !== 32'hDEBB20E3) begin
        $display("FAIL crc_residue N=%0d: got %h, expected debb20e3", n, c);
        n_bad++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int gn, en, bad, b_rd, b_pct;
    bit ok;
    // Both packets queued with transmit enabled throughout.
    gaps.delete();
    b_rd = rd_count; b_pct = pct_count;
    eth_tx_en = 1'b1;
    queue_packet(10, 8'h10, 1'b1);
    queue_packet(20, 8'h20, 1'b1);
    wait_frames(2, 800, ok);
    n_cmp++;
    if (!ok) begin
      $display("FAIL b2b_timeout: got %0d frames, expected 2", rx_lens.size());
      n_bad++;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      pop_frame(gn, en);
      n_cmp++;
      bad = (gn !== en) ? 1 : 0;
      for (int i = 0; i < gn && i < en; i++) if (got_q[i] !== want_q[i]) bad++;
      if (bad != 0) begin
        $display("FAIL b2b_frame%0d: %0d bad bytes, got len %0d expected %0d", k, bad, gn, en);
        n_bad++;
      end
    end
    n_cmp++;
    if (gaps.size() == 0 || gaps[gaps.size()-1] < IFG) begin
      $display("FAIL b2b_gap: got %0d idle cycles, expected at least %0d", (gaps.size() == 0) ? -1 : gaps[gaps.size()-1], IFG);
      n_bad++;
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (rd_count - b_rd !== 34 || pct_count - b_pct !== 2) begin
      $display("FAIL b2b_counts: got %0d reads %0d pulses, expected 34 reads 2 pulses", rd_count - b_rd, pct_count - b_pct);
      n_bad++;
    end
    // Transmit enable dropped during the first frame.
    queue_packet(5, 8'h30, 1'b1);
    queue_packet(5, 8'h50, 1'b1);
    for (int i = 0; i < 50 && !tx_en_o; i++) @(negedge clk);
    eth_tx_en = 1'b0;
    wait_frames(1, 200, ok);
    repeat (50) @(negedge clk);
    n_cmp++;
    if (!ok || rx_lens.size() !== 1 || tx_en_o !== 1'b0 || cur.size() !== 0) begin
      $display("FAIL txen_drop: got %0d frames (busy=%b), expected exactly 1 and idle", rx_lens.size(), tx_en_o);
      n_bad++;
    end
    eth_tx_en = 1'b1;
    wait_frames(2, 300, ok);
    n_cmp++;
    if (!ok) begin
      $display("FAIL txen_resume: got %0d frames, expected 2", rx_lens.size());
      n_bad++;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      pop_frame(gn, en);
      n_cmp++;
      bad = (gn !== en) ? 1 : 0;
      for (int i = 0; i < gn && i < en; i++) if (got_q[i] !== want_q[i]) bad++;
      if (bad != 0) begin
        $display("FAIL txen_frame%0d: %0d bad bytes, got len %0d expected %0d", k, bad, gn, en);
        n_bad++;
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int b_rd, b_pct, b_tx, gn, en, bad;
    bit ok;
    b_rd = rd_count; b_pct = pct_count;
    eth_tx_en = 1'b1;
    queue_packet(30, 8'h60, 1'b0);
    for (int i = 0; i < 200 && (rd_count - b_rd) < 12; i++) @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx_en_o, r_en, pct, txd} !== 11'h000) begin
      $display("FAIL abort_outputs: got en=%b r_en=%b pct=%b txd=%h, expected all 0", tx_en_o, r_en, pct, txd);
      n_bad++;
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pct_count - b_pct !== 0) begin
      $display("FAIL abort_pct: got %0d pulses, expected 0", pct_count - b_pct);
      n_bad++;
    end
    fifo_q.delete();
    pkts_queued = pkts_done;
    rx_lens.delete();
    rx_bytes.delete();
    arst_n = 1'b1;
    b_tx = tx_cycles;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (tx_cycles - b_tx !== 0) begin
      $display("FAIL abort_restart: got %0d tx_en cycles with no packet, expected 0", tx_cycles - b_tx);
      n_bad++;
    end
    b_pct = pct_count;
    queue_packet(12, 8'h70, 1'b1);
    wait_frames(1, 400, ok);
    n_cmp++;
    if (!ok) begin
      $display("FAIL abort_fresh_timeout: no frame within 400 cycles");
      n_bad++;
      return;
    end
    pop_frame(gn, en);
    n_cmp++;
    bad = (gn !== en) ? 1 : 0;
    for (int i = 0; i < gn && i < en; i++) if (got_q[i] !== want_q[i]) bad++;
    if (bad != 0) begin
      $display("FAIL abort_fresh_frame: %0d bad bytes, got len %0d expected %0d", bad, gn, en);
      n_bad++;
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (pct_count - b_pct !== 1) begin
      $display("FAIL abort_fresh_pct: got %0d pulses, expected 1", pct_count - b_pct);
      n_bad++;
    end
  endtask

  initial begin
    test_reset();
    test_no_packet();
    test_single_frame(46, 8'h00, 1'b0);
    test_single_frame(10, 8'h40, 1'b1);
    test_single_frame(100, 8'h80, 1'b1);
    test_single_frame(0, 8'h00, 1'b1);
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
